ofm_writeback: RTL and testbench

//  Consumes the 8-bit quantized/ReLU'd OFM stream (ofm_output + ready_write pulse) from the activation stage.

---
 rtl/ofm_wb_pkg.sv | 34 +++
 rtl/ofm_wb_fifo.sv | 58 +++++
 rtl/ofm_writeback.sv | 146 ++++++++++++++
 tb/tb_ofm_writeback.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_wb_pkg.sv
// Shared types and constants for the OFM writeback block.
// The optional zero counter in ofm_writeback is enabled by OFM_WRITEBACK_ZCNT_EN.
package ofm_wb_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int LANES      = 4;
    localparam int ADDR_WIDTH = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int WORD_WIDTH = DATA_WIDTH * LANES;
    localparam int LANE_CNT_W = $clog2(LANES);
    localparam int CNT_W      = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } wb_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
        logic [LANES-1:0]      strb;
    } wb_word_t;

    // Byte enables for lanes 0..last inclusive
    function automatic logic [LANES-1:0] lane_mask(input logic [LANE_CNT_W-1:0] last);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (LANE_CNT_W'(i) <= last);
        end
        return m;
    endfunction

endpackage

// File: rtl/ofm_wb_fifo.sv
// Show-ahead word FIFO; a push into a full FIFO succeeds only when a pop happens on the same edge.
module ofm_wb_fifo
    import ofm_wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  wb_word_t wr_word,
    input  logic     pop,
    output wb_word_t rd_word,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_word_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_word = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofm_writeback.sv
// Packs the activation byte stream into words and writes one OFM tile to memory.
// Define OFM_WRITEBACK_ZCNT_EN to add the zero_count sparsity output.
module ofm_writeback
    import ofm_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0]      num_elems,
    input  logic                  ready_write,
    input  logic [DATA_WIDTH-1:0] ofm_output,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [WORD_WIDTH-1:0] mem_wr_data,
    output logic [LANES-1:0]      mem_wr_strb,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
`ifdef OFM_WRITEBACK_ZCNT_EN
    ,
    output logic [CNT_W-1:0]      zero_count
`endif
);

    wb_state_t             state;
    logic [CNT_W-1:0]      num_q;
    logic [CNT_W-1:0]      elem_cnt;
    logic [LANE_CNT_W-1:0] lane_cnt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [WORD_WIDTH-1:0] pack_reg;
    logic [WORD_WIDTH-1:0] pack_next;

    logic     accept;
    logic     last_elem;
    logic     close_word;
    logic     pop;
    logic     fifo_full;
    logic     fifo_empty;
    wb_word_t push_word;
    wb_word_t head_word;

    assign accept     = (state == RUN) && ready_write;
    assign last_elem  = (elem_cnt == num_q - CNT_W'(1));
    assign close_word = accept && ((lane_cnt == LANE_CNT_W'(LANES-1)) || last_elem);
    assign pack_next  = pack_reg | (WORD_WIDTH'(ofm_output) << (DATA_WIDTH * lane_cnt));
    assign pop        = mem_wr_valid && mem_wr_ready;

    always_comb begin
        push_word      = '0;
        push_word.addr = addr_cnt;
        push_word.data = pack_next;
        push_word.strb = lane_mask(lane_cnt);
    end

    ofm_wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (close_word),
        .wr_word(push_word),
        .pop    (pop),
        .rd_word(head_word),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Gate the head entry so stale FIFO contents never show on an idle port
    assign mem_wr_valid = !fifo_empty;
    assign mem_wr_addr  = mem_wr_valid ? head_word.addr : '0;
    assign mem_wr_data  = mem_wr_valid ? head_word.data : '0;
    assign mem_wr_strb  = mem_wr_valid ? head_word.strb : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            num_q    <= '0;
            elem_cnt <= '0;
            lane_cnt <= '0;
            addr_cnt <= '0;
            pack_reg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt <= base_addr;
                        num_q    <= num_elems;
                        elem_cnt <= '0;
                        lane_cnt <= '0;
                        pack_reg <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (num_elems == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + CNT_W'(1);
                        if (close_word) begin
                            pack_reg <= '0;
                            lane_cnt <= '0;
                            // A dropped word still consumes its address slot
                            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                            if (fifo_full && !pop) begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            pack_reg <= pack_next;
                            lane_cnt <= lane_cnt + LANE_CNT_W'(1);
                        end
                        if (last_elem) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OFM_WRITEBACK_ZCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_count <= '0;
        end else if (state == IDLE && start) begin
            zero_count <= '0;
        end else if (accept && ofm_output == '0) begin
            zero_count <= zero_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed self-checking bench for ofm_writeback.
// The zero_count checks are compiled in when OFM_WRITEBACK_ZCNT_EN is defined.
module tb_ofm_writeback;
    import ofm_wb_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_W-1:0]      num_elems;
    logic                  ready_write;
    logic [DATA_WIDTH-1:0] ofm_output;
    logic                  mem_wr_valid;
    logic                  mem_wr_ready;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [WORD_WIDTH-1:0] mem_wr_data;
    logic [LANES-1:0]      mem_wr_strb;
    logic                  busy;
    logic                  done;
    logic                  overflow;
`ifdef OFM_WRITEBACK_ZCNT_EN
    logic [CNT_W-1:0]      zero_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int done_seen    = 0;
    int prev_done;

    logic [ADDR_WIDTH-1:0] wr_addr_q[$];
    logic [WORD_WIDTH-1:0] wr_data_q[$];
    logic [LANES-1:0]      wr_strb_q[$];

    always #5 clk = ~clk;

    ofm_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_elems   (num_elems),
        .ready_write (ready_write),
        .ofm_output  (ofm_output),
        .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_strb (mem_wr_strb),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
`ifdef OFM_WRITEBACK_ZCNT_EN
        ,
        .zero_count  (zero_count)
`endif
    );

    // Records every transfer that will happen on the next rising edge, and done pulses
    always @(negedge clk) begin
        #1;
        if (!rst && mem_wr_valid && mem_wr_ready) begin
            wr_addr_q.push_back(mem_wr_addr);
            wr_data_q.push_back(mem_wr_data);
            wr_strb_q.push_back(mem_wr_strb);
        end
        if (!rst && done) begin
            done_seen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [ADDR_WIDTH-1:0] addr,
                              input logic [WORD_WIDTH-1:0] data, input logic [LANES-1:0] strb);
        if (idx >= wr_addr_q.size()) begin
            checkOutput({tag, "_missing"}, 64'(wr_addr_q.size()), 64'(idx + 1));
        end else begin
            checkOutput({tag, "_addr"}, wr_addr_q[idx], addr);
            checkOutput({tag, "_data"}, wr_data_q[idx], data);
            checkOutput({tag, "_strb"}, wr_strb_q[idx], strb);
        end
    endtask

    task automatic clearWrites();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_strb_q.delete();
    endtask

    task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] base, input logic [CNT_W-1:0] n);
        @(negedge clk);
        base_addr = base;
        num_elems = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic sendByte(input logic [DATA_WIDTH-1:0] b);
        @(negedge clk);
        ready_write = 1'b1;
        ofm_output  = b;
    endtask

    task automatic endBytes();
        @(negedge clk);
        ready_write = 1'b0;
        ofm_output  = '0;
    endtask

    task automatic waitDone(input string tag, input int prev, input int budget);
        for (int k = 0; k < budget && done_seen == prev; k++) begin
            @(negedge clk);
            #2;
        end
        checkOutput({tag, "_done_seen"}, 64'(done_seen > prev), 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_elems    = '0;
        ready_write  = 1'b0;
        ofm_output   = '0;
        mem_wr_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", mem_wr_valid, 0);
        checkOutput("rst_addr", mem_wr_addr, 0);
        checkOutput("rst_data", mem_wr_data, 0);
        checkOutput("rst_strb", mem_wr_strb, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_overflow", overflow, 0);
`ifdef OFM_WRITEBACK_ZCNT_EN
        checkOutput("rst_zero_count", zero_count, 0);
`endif
        rst = 1'b0;

        // Test 1: 8 bytes, two full words at 0x10/0x11
        $display("[TB] test 1: two full words");
        clearWrites();
        prev_done = done_seen;
        applyStimulus(16'h0010, 18'd8);
        #1;
        checkOutput("t1_busy_run", busy, 1);
        for (int i = 1; i <= 8; i++) sendByte(8'(i));
        endBytes();
        waitDone("t1", prev_done, 50);
        @(negedge clk);
        #2;
        checkOutput("t1_done_count", 64'(done_seen - prev_done), 1);
        checkOutput("t1_busy_after", busy, 0);
        checkOutput("t1_nwrites", 64'(wr_addr_q.size()), 2);
        checkWrite("t1_w0", 0, 16'h0010, 32'h04030201, 4'hF);
        checkWrite("t1_w1", 1, 16'h0011, 32'h08070605, 4'hF);

        // Test 2: 6 bytes, partial last word, plus one-cycle push latency
        $display("[TB] test 2: partial word");
        clearWrites();
        prev_done = done_seen;
        applyStimulus(16'h0000, 18'd6);
        for (int i = 0; i < 6; i++) begin
            sendByte(8'hA0 + 8'(i));
            if (i == 3) begin
                #1;
                checkOutput("t2_valid_before_close", mem_wr_valid, 0);
            end
            if (i == 4) begin
                #1;
                checkOutput("t2_valid_after_close", mem_wr_valid, 1);
            end
        end
        endBytes();
        waitDone("t2", prev_done, 50);
        checkOutput("t2_nwrites", 64'(wr_addr_q.size()), 2);
        checkWrite("t2_w0", 0, 16'h0000, 32'hA3A2A1A0, 4'hF);
        checkWrite("t2_w1", 1, 16'h0001, 32'h0000A5A4, 4'h3);

        // Test 3: memory stalled for 20 bytes, fifth word dropped
        $display("[TB] test 3: overflow");
        clearWrites();
        prev_done = done_seen;
        mem_wr_ready = 1'b0;
        applyStimulus(16'h0100, 18'd24);
        for (int i = 1; i <= 24; i++) begin
            sendByte(8'(i));
            if (i == 20) begin
                #1;
                checkOutput("t3_overflow_before_drop", overflow, 0);
            end
            if (i == 21) begin
                mem_wr_ready = 1'b1;
                #1;
                checkOutput("t3_overflow_after_drop", overflow, 1);
            end
        end
        endBytes();
        waitDone("t3", prev_done, 100);
        checkOutput("t3_nwrites", 64'(wr_addr_q.size()), 5);
        checkWrite("t3_w0", 0, 16'h0100, 32'h04030201, 4'hF);
        checkWrite("t3_w3", 3, 16'h0103, 32'h100F0E0D, 4'hF);
        checkWrite("t3_w4", 4, 16'h0105, 32'h18171615, 4'hF);
        checkOutput("t3_overflow_sticky", overflow, 1);

        // Test 4: empty tile, done two cycles after start, overflow cleared
        $display("[TB] test 4: empty tile");
        clearWrites();
        applyStimulus(16'h0020, 18'd0);
        #1;
        checkOutput("t4_done_early", done, 0);
        checkOutput("t4_busy", busy, 1);
        checkOutput("t4_overflow_cleared", overflow, 0);
        @(negedge clk);
        #1;
        checkOutput("t4_done_pulse", done, 1);
        checkOutput("t4_valid", mem_wr_valid, 0);
        @(negedge clk);
        #1;
        checkOutput("t4_done_low", done, 0);
        checkOutput("t4_busy_low", busy, 0);
        checkOutput("t4_nwrites", 64'(wr_addr_q.size()), 0);

        // Test 5: address wrap, start ignored while busy
        $display("[TB] test 5: wrap and ignored start");
        clearWrites();
        prev_done = done_seen;
        applyStimulus(16'hFFFF, 18'd8);
        sendByte(8'h01);
        sendByte(8'h02);
        @(negedge clk);
        ready_write = 1'b0;
        base_addr   = 16'h1234;
        num_elems   = 18'd4;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        ready_write = 1'b0;
        for (int i = 3; i <= 8; i++) sendByte(8'(i));
        endBytes();
        waitDone("t5", prev_done, 50);
        checkOutput("t5_nwrites", 64'(wr_addr_q.size()), 2);
        checkWrite("t5_w0", 0, 16'hFFFF, 32'h04030201, 4'hF);
        checkWrite("t5_w1", 1, 16'h0000, 32'h08070605, 4'hF);

        // Test 5b: reset mid-tile with a word pending
        $display("[TB] test 5b: reset mid-tile");
        mem_wr_ready = 1'b0;
        applyStimulus(16'h0040, 18'd8);
        for (int i = 0; i < 5; i++) sendByte(8'h11 + 8'(i));
        #1;
        checkOutput("t5b_valid_pending", mem_wr_valid, 1);
        checkOutput("t5b_busy_pending", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("t5b_rst_valid", mem_wr_valid, 0);
        checkOutput("t5b_rst_addr", mem_wr_addr, 0);
        checkOutput("t5b_rst_data", mem_wr_data, 0);
        checkOutput("t5b_rst_busy", busy, 0);
        endBytes();
        @(negedge clk);
        rst = 1'b0;
        prev_done = done_seen;
        repeat (5) @(negedge clk);
        #2;
        checkOutput("t5b_no_done", 64'(done_seen), 64'(prev_done));
        checkOutput("t5b_idle_valid", mem_wr_valid, 0);
        mem_wr_ready = 1'b1;

`ifdef OFM_WRITEBACK_ZCNT_EN
        // Test 6: zero counter
        $display("[TB] test 6: zero count");
        clearWrites();
        prev_done = done_seen;
        applyStimulus(16'h0000, 18'd4);
        sendByte(8'h00);
        sendByte(8'h05);
        sendByte(8'h00);
        sendByte(8'h00);
        endBytes();
        waitDone("t6", prev_done, 50);
        checkOutput("t6_zero_count", zero_count, 3);
        checkWrite("t6_w0", 0, 16'h0000, 32'h00000500, 4'hF);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
